// File: rtl/ebr_spi_reader.sv
// Read side of the camera line buffer: streams a fill-level header then buffered EBR bytes as an SPI mode-0 slave.
// All logic on xclk; sck/scsn oversampled, one-byte prefetch keeps the next byte ready before each byte boundary.
module ebr_spi_reader #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              xclk,
  input  logic              rstn,
  input  logic              sck,
  input  logic              scsn,
  output logic              miso,
  input  logic [ADDR_W-1:0] wrPtr,
  output logic [ADDR_W-1:0] rdPtr,
  output logic [ADDR_W-1:0] ebrRAddr,
  output logic              ebrRE,
  input  logic [DATA_W-1:0] ebrRData,
  output logic              busy,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] HDR_MAX  = ADDR_W'((1 << DATA_W) - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sck_sync, scsn_sync;
  logic               sck_d, scsn_d;
  logic [DATA_W-1:0]  shreg, next_byte;
  logic [CNT_W-1:0]   bit_cnt;
  logic               data_in_shreg, next_valid, rd_cap;

  logic               sck_s, scsn_s, sck_fall, scsn_fall, scsn_rise, boundary;
  logic [ADDR_W-1:0]  level, pf_addr;
  logic [DATA_W-1:0]  hdr;
  logic               pf_go;

  // Idle values on reset so releasing reset never looks like an edge.
  always_ff @(posedge xclk) begin
    if (!rstn) begin
      sck_sync  <= '0;
      scsn_sync <= '1;
      sck_d     <= 1'b0;
      scsn_d    <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      scsn_sync <= {scsn_sync[SYNC_STAGES-2:0], scsn};
      sck_d     <= sck_s;
      scsn_d    <= scsn_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign scsn_s    = scsn_sync[SYNC_STAGES-1];
  assign sck_fall  = sck_d & ~sck_s;
  assign scsn_fall = scsn_d & ~scsn_s;
  assign scsn_rise = ~scsn_d & scsn_s;
  assign boundary  = sck_fall && (bit_cnt == LAST_BIT);

  assign level   = wrPtr - rdPtr;
  assign hdr     = (level > HDR_MAX) ? '1 : DATA_W'(level);
  assign pf_addr = rdPtr + ADDR_W'(data_in_shreg);
  // A prefetch is held off on a boundary cycle so its address reflects the post-commit pointer.
  assign pf_go   = (state == SHIFT) && !scsn_rise && !next_valid && !ebrRE && !rd_cap &&
                   ((wrPtr - pf_addr) != '0) && !boundary;

  assign miso = (state == SHIFT) & shreg[DATA_W-1];
  assign busy = (state == SHIFT);

  always_ff @(posedge xclk) begin
    if (!rstn) begin
      state         <= IDLE;
      shreg         <= '0;
      next_byte     <= '0;
      bit_cnt       <= '0;
      data_in_shreg <= 1'b0;
      next_valid    <= 1'b0;
      rd_cap        <= 1'b0;
      rdPtr         <= '0;
      ebrRAddr      <= '0;
      ebrRE         <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      underrun <= 1'b0;
      ebrRE    <= 1'b0;
      rd_cap   <= ebrRE;
      case (state)
        IDLE: begin
          if (scsn_fall) begin
            shreg         <= hdr;
            bit_cnt       <= '0;
            data_in_shreg <= 1'b0;
            next_valid    <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (scsn_rise) begin
            // Abort: uncommitted byte is resent next time, in-flight read dropped.
            state      <= IDLE;
            next_valid <= 1'b0;
            rd_cap     <= 1'b0;
          end else begin
            if (rd_cap) begin
              next_byte  <= ebrRData;
              next_valid <= 1'b1;
            end
            if (sck_fall) begin
              if (bit_cnt != LAST_BIT) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end else begin
                bit_cnt <= '0;
                if (data_in_shreg) rdPtr <= rdPtr + 1'b1;
                if (next_valid) begin
                  shreg         <= next_byte;
                  data_in_shreg <= 1'b1;
                  next_valid    <= 1'b0;
                end else begin
                  shreg         <= '0;
                  data_in_shreg <= 1'b0;
                  underrun      <= 1'b1;
                end
              end
            end
            if (pf_go) begin
              ebrRE    <= 1'b1;
              ebrRAddr <= pf_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebr_spi_reader.sv
// Directed bench for ebr_spi_reader: table of SPI transactions against a behavioural EBR, plus a mid-byte reset sequence.
module tb_ebr_spi_reader;

  localparam int HALF = 5;  // sck half period in xclk cycles

  logic       xclk = 1'b0;
  logic       rstn, sck, scsn, miso, ebrRE, busy, underrun;
  logic [8:0] wrPtr, rdPtr, ebrRAddr;
  logic [7:0] ebrRData;
  logic [7:0] mem [512];

  int  n_vec = 0;
  int  n_bad = 0;
  int  unr_total = 0;
  bit  counting = 1'b0;

  ebr_spi_reader #(.ADDR_W(9), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .xclk(xclk), .rstn(rstn), .sck(sck), .scsn(scsn), .miso(miso),
    .wrPtr(wrPtr), .rdPtr(rdPtr), .ebrRAddr(ebrRAddr), .ebrRE(ebrRE),
    .ebrRData(ebrRData), .busy(busy), .underrun(underrun)
  );

  always #5 xclk = ~xclk;

  always @(posedge xclk) if (ebrRE) ebrRData <= mem[ebrRAddr];

  always @(negedge xclk) if (counting && underrun) unr_total++;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit              rst;
    logic [8:0]      wr;
    int              nbytes;
    int              abort_bits;
    int              nchk;
    logic [0:5][7:0] exp;
    logic [8:0]      exp_rd;
    int              exp_unr;
    logic [8:0]      init_addr;
    int              init_n;
    logic [0:3][7:0] init_dat;
  } vec_t;

  vec_t vecs [7];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge xclk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; sck = 1'b0; scsn = 1'b1;
    wait_cyc(2);
    rstn = 1'b1;
    wait_cyc(2);
  endtask

  // Underruns are counted up to, not including, the final falling edge of a completed
  // transaction: that last boundary only preloads a byte the host never clocks out.
  task automatic spi_txn(input string tag, input int nbytes, input int abort_bits,
                         input int nchk, input logic [0:5][7:0] exp, output int unr);
    logic [7:0] byte_v;
    int u0;
    u0 = unr_total;
    counting = 1'b1;
    scsn = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      byte_v = '0;
      for (int b = 0; b < 8; b++) begin
        wait_cyc(HALF);
        byte_v = {byte_v[6:0], miso};
        sck = 1'b1;
        wait_cyc(HALF);
        if (abort_bits == 0 && i == nbytes - 1 && b == 7) counting = 1'b0;
        sck = 1'b0;
      end
      if (i < nchk) check($sformatf("%s byte%0d", tag, i), int'(byte_v), int'(exp[i]));
    end
    for (int b = 0; b < abort_bits; b++) begin
      wait_cyc(HALF); sck = 1'b1;
      wait_cyc(HALF); sck = 1'b0;
    end
    wait_cyc(HALF);
    counting = 1'b0;
    scsn = 1'b1;
    wait_cyc(2 * HALF);
    unr = unr_total - u0;
  endtask

  initial begin
    int unr;
    rstn = 1'b0; sck = 1'b0; scsn = 1'b1; wrPtr = '0; ebrRData = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;

    vecs[0] = '{rst:1'b1, wr:9'd0,   nbytes:2,   abort_bits:0, nchk:2, exp:{8'h00,8'h00,32'h0},
                exp_rd:9'd0,   exp_unr:1, init_addr:9'd0,   init_n:0, init_dat:32'h0};
    vecs[1] = '{rst:1'b1, wr:9'd3,   nbytes:4,   abort_bits:0, nchk:4, exp:{8'h03,8'hA5,8'h3C,8'hF0,16'h0},
                exp_rd:9'd3,   exp_unr:0, init_addr:9'd0,   init_n:3, init_dat:{8'hA5,8'h3C,8'hF0,8'h00}};
    vecs[2] = '{rst:1'b1, wr:9'd300, nbytes:2,   abort_bits:0, nchk:2, exp:{8'hFF,8'h11,32'h0},
                exp_rd:9'd1,   exp_unr:0, init_addr:9'd0,   init_n:1, init_dat:{8'h11,24'h0}};
    vecs[3] = '{rst:1'b1, wr:9'd2,   nbytes:2,   abort_bits:4, nchk:2, exp:{8'h02,8'h11,32'h0},
                exp_rd:9'd1,   exp_unr:0, init_addr:9'd0,   init_n:2, init_dat:{8'h11,8'h22,16'h0}};
    vecs[4] = '{rst:1'b0, wr:9'd2,   nbytes:2,   abort_bits:0, nchk:2, exp:{8'h01,8'h22,32'h0},
                exp_rd:9'd2,   exp_unr:0, init_addr:9'd0,   init_n:0, init_dat:32'h0};
    vecs[5] = '{rst:1'b1, wr:9'd510, nbytes:511, abort_bits:0, nchk:1, exp:{8'hFF,40'h0},
                exp_rd:9'd510, exp_unr:0, init_addr:9'd0,   init_n:0, init_dat:32'h0};
    vecs[6] = '{rst:1'b0, wr:9'd2,   nbytes:5,   abort_bits:0, nchk:5, exp:{8'h04,8'h01,8'h02,8'h03,8'h04,8'h00},
                exp_rd:9'd2,   exp_unr:0, init_addr:9'd510, init_n:4, init_dat:{8'h01,8'h02,8'h03,8'h04}};

    wait_cyc(3);
    check("reset miso", int'(miso), 0);
    check("reset busy", int'(busy), 0);
    check("reset rdPtr", int'(rdPtr), 0);
    check("reset ebrRAddr", int'(ebrRAddr), 0);
    check("reset ebrRE", int'(ebrRE), 0);
    check("reset underrun", int'(underrun), 0);
    rstn = 1'b1;
    wait_cyc(2);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      for (int k = 0; k < vecs[v].init_n; k++) mem[9'(vecs[v].init_addr + 9'(k))] = vecs[v].init_dat[k];
      wrPtr = vecs[v].wr;
      wait_cyc(2);
      spi_txn($sformatf("vec%0d", v), vecs[v].nbytes, vecs[v].abort_bits, vecs[v].nchk, vecs[v].exp, unr);
      check($sformatf("vec%0d rdPtr", v), int'(rdPtr), int'(vecs[v].exp_rd));
      check($sformatf("vec%0d underruns", v), unr, vecs[v].exp_unr);
    end

    // Reset pulse three bits into a header byte, then a clean restart.
    scsn = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wait_cyc(HALF); sck = 1'b1;
      wait_cyc(HALF); sck = 1'b0;
    end
    wait_cyc(2);
    rstn = 1'b0;
    wait_cyc(1);
    check("midrst miso", int'(miso), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst rdPtr", int'(rdPtr), 0);
    check("midrst ebrRE", int'(ebrRE), 0);
    rstn = 1'b1;
    scsn = 1'b1;
    wait_cyc(4 * HALF);
    spi_txn("restart", 2, 0, 2, {8'h02, 8'h03, 32'h0}, unr);
    check("restart rdPtr", int'(rdPtr), 1);
    check("restart underruns", unr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
